// File: rtl/serial_addsub_if.sv
// rtl/serial_addsub_if.sv - request/result bundle for the chunked serial adder/subtractor
//
// Purpose: groups the operation request (start, a, b, sub) and the status/result
// outputs (busy, done, result, zf, nz, cf, of) of serial_addsub.
// Modports:
//   master - drives start/a/b/sub, observes busy/done/result/flags
//   slave  - the serial_addsub side
interface serial_addsub_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zf;
  logic        nz;
  logic        cf;
  logic        of;

  modport master (
    output start, a, b, sub,
    input  busy, done, result, zf, nz, cf, of
  );

  modport slave (
    input  start, a, b, sub,
    output busy, done, result, zf, nz, cf, of
  );
endinterface

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - 32-bit add/subtract processed CHUNK_W bits per cycle
//
// Purpose: computes a+b or a-b over N = 32/CHUNK_W cycles, LSB slice first, and
// publishes the result together with zero/non-zero/carry/overflow flags.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - serial_addsub_if.slave: start/a/b/sub in; busy/done/result/zf/nz/cf/of out
// Parameter:
//   CHUNK_W - bits per cycle (4, 8 or 16)
module serial_addsub #(
  parameter int CHUNK_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_addsub_if.slave bus
);

  localparam int N     = 32 / CHUNK_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  // op_a doubles as the partial-sum register: each cycle its low slice is
  // consumed and the new sum slice enters at the top, so after N cycles it
  // holds the whole result.
  logic [31:0]      op_a_q;
  logic [31:0]      op_b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;

  logic [31:0] result_q;
  logic        zf_q, nz_q, cf_q, of_q;

  logic             accept;
  logic             last;
  logic [CHUNK_W:0] slice_sum;
  logic [31:0]      full_sum;
  logic             carry_into_msb;

  always_comb begin
    accept    = bus.start && (state_q != RUN);
    last      = (idx_q == IDX_W'(N - 1));
    slice_sum = {1'b0, op_a_q[CHUNK_W-1:0]} + {1'b0, op_b_q[CHUNK_W-1:0]}
              + {{CHUNK_W{1'b0}}, carry_q};
    full_sum  = {slice_sum[CHUNK_W-1:0], op_a_q[31:CHUNK_W]};
    // Sum bit = a ^ b ^ carry_in, so the carry into the top bit of the slice
    // is recovered from the sum bit and both operand bits.
    carry_into_msb = slice_sum[CHUNK_W-1] ^ op_a_q[CHUNK_W-1] ^ op_b_q[CHUNK_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last)   state_d = DONE;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      zf_q     <= 1'b0;
      nz_q     <= 1'b0;
      cf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
      op_a_q  <= bus.a;
      op_b_q  <= bus.sub ? ~bus.b : bus.b;
      carry_q <= bus.sub;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      op_a_q  <= full_sum;
      op_b_q  <= {{CHUNK_W{1'b0}}, op_b_q[31:CHUNK_W]};
      carry_q <= slice_sum[CHUNK_W];
      idx_q   <= idx_q + IDX_W'(1);
      if (last) begin
        result_q <= full_sum;
        zf_q     <= (full_sum == 32'd0);
        nz_q     <= (full_sum != 32'd0);
        cf_q     <= slice_sum[CHUNK_W];
        of_q     <= slice_sum[CHUNK_W] ^ carry_into_msb;
      end
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.zf     = zf_q;
  assign bus.nz     = nz_q;
  assign bus.cf     = cf_q;
  assign bus.of     = of_q;

endmodule
